// File: rtl/mealy_name_pkg.sv
// Shared constants for the 10010 serial sequence detector: state
// encodings, the fixed pattern, and a state-name decoder for waveforms
// and bench messages.
package mealy_name_pkg;

  // State encodings; each name records how much of the pattern is matched
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_S1    = 3'd1;
  localparam logic [2:0] ST_S10   = 3'd2;
  localparam logic [2:0] ST_S100  = 3'd3;
  localparam logic [2:0] ST_S1001 = 3'd4;

  // Pattern to detect, oldest bit in the MSB
  localparam logic [4:0] PATTERN = 5'b10010;

  // Five-character ASCII name of a state encoding
  function automatic logic [39:0] state_name(input logic [2:0] s);
    logic [39:0] name;
    case (s)
      ST_IDLE:  name = "IDLE ";
      ST_S1:    name = "S1   ";
      ST_S10:   name = "S10  ";
      ST_S100:  name = "S100 ";
      ST_S1001: name = "S1001";
      default:  name = "BAD  ";
    endcase
    return name;
  endfunction

endpackage

// File: rtl/mealy_name.sv
// Mealy detector for the serial pattern 10010 with overlap. k is
// combinational from the current state and A, so a downstream consumer
// sees the detect at the same edge that consumes the final 0.
module mealy_name
  import mealy_name_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  output logic k
);

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic       a_bit;

  // Clean copy of A: an unknown or floating input counts as 0
  always_comb begin
    a_bit = 1'b0;
    case (A)
      1'b1:    a_bit = 1'b1;
      default: a_bit = 1'b0;
    endcase
  end

  // State register; reset discards any partial match immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; after a detection the trailing 10 is kept for overlap
  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE:  state_next = a_bit ? ST_S1    : ST_IDLE;
      ST_S1:    state_next = a_bit ? ST_S1    : ST_S10;
      ST_S10:   state_next = a_bit ? ST_S1    : ST_S100;
      ST_S100:  state_next = a_bit ? ST_S1001 : ST_IDLE;
      ST_S1001: state_next = a_bit ? ST_S1    : ST_S10;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Mealy output: the final 0 arriving while 1001 is matched
  always_comb begin
    k = 1'b0;
    if (state_reg == ST_S1001 && !a_bit) begin
      k = 1'b1;
    end
  end

  // A detect is only legal on the last pattern bit in the S1001 state
  a_k_implies_match: assert property (
    @(posedge clk) disable iff (!rst_n)
    k |-> (state_reg == ST_S1001 && a_bit == PATTERN[0])
  );

  // The register never holds an unused encoding once out of reset
  a_state_legal: assert property (
    @(posedge clk) disable iff (!rst_n)
    state_reg <= ST_S1001
  );

endmodule

// File: tb/tb_mealy_name.sv
// Bench for mealy_name: the driver pushes the expected k for every cycle
// it drives, and a negedge monitor pops and compares. The reference keeps
// the last bits seen since reset and matches them against PATTERN.
`timescale 1ns/1ps
module tb_mealy_name;
  import mealy_name_pkg::*;

  logic clk;
  logic rst_n;
  logic A;
  logic k;

  mealy_name dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .k     (k)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   det_count = 0;
  int   cyc = 0;

  // Reference model state: bits consumed since reset
  logic [3:0] hist;
  int         nbits;

  always @(posedge clk) cyc <= cyc + 1;

  // Present one bit on A and record the expected k for this cycle
  task automatic drive(input logic a);
    logic [4:0] window;
    logic       exp_k;
    A      = a;
    window = {hist, a};
    exp_k  = (nbits >= 4) && (window == PATTERN);
    sb_q.push_back(exp_k);
    hist  = {hist[2:0], a};
    nbits = nbits + 1;
  endtask

  task automatic step(input logic a);
    @(posedge clk);
    #1;
    drive(a);
  endtask

  // Hold reset for a number of cycles with A toggling, then release
  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    hist  = 4'b0;
    nbits = 0;
    for (int i = 0; i < cycles; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      A = (i == 0) ? 1'b0 : 1'($urandom % 2);
      sb_q.push_back(1'b0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.state_reg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: state=%s required=%s",
               state_name(dut.state_reg), state_name(ST_IDLE));
    end
    rst_n = 1'b1;
    drive(1'b0);
  endtask

  // Drive the n low bits of seq, most significant (oldest) first
  task automatic run_seq(input logic [31:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(seq[i]);
    end
  endtask

  // Compare detections seen since start against a fixed count
  task automatic check_hits(input string name, input int start, input int want);
    @(negedge clk);
    #1;
    n_checks++;
    if (det_count - start != want) begin
      n_fail++;
      $display("FAIL %s: detections=%0d required=%0d", name, det_count - start, want);
    end
  endtask

  // Monitor: pop the expected k for every driven cycle and compare
  always @(negedge clk) begin
    logic exp_k;
    if (sb_q.size() > 0) begin
      exp_k = sb_q.pop_front();
      n_checks++;
      if (k === 1'b1) det_count++;
      if (k !== exp_k) begin
        n_fail++;
        $display("FAIL k_check cyc=%0d A=%b state=%s k=%b required=%b",
                 cyc, A, state_name(dut.state_reg), k, exp_k);
      end else begin
        $display("cyc=%0d rst_n=%b A=%b k=%b exp=%b", cyc, rst_n, A, k, exp_k);
      end
    end
  end

  initial begin
    int start;
    rst_n = 1'b0;
    A     = 1'b0;
    hist  = 4'b0;
    nbits = 0;

    // Reset with A toggling
    do_reset(2);

    // Single match
    do_reset(1);
    start = det_count;
    run_seq(32'b10010, 5);
    step(1'b0);
    check_hits("single", start, 1);

    // Overlapping matches
    do_reset(1);
    start = det_count;
    run_seq(32'b10010010, 8);
    check_hits("overlap", start, 2);

    // Near misses
    do_reset(1);
    start = det_count;
    run_seq(32'b100010, 6);
    check_hits("near_miss_a", start, 0);
    do_reset(1);
    start = det_count;
    run_seq(32'b10110, 5);
    check_hits("near_miss_b", start, 0);

    // Recovery: 1001100 leaves 100 matched, so 1,0 completes the pattern
    do_reset(1);
    start = det_count;
    run_seq(32'b1001100, 7);
    check_hits("recover_pre", start, 0);
    start = det_count;
    run_seq(32'b10, 2);
    check_hits("recover", start, 1);

    // Reset mid-pattern discards the 1001 prefix
    do_reset(1);
    run_seq(32'b1001, 4);
    do_reset(1);
    start = det_count;
    step(1'b0);
    check_hits("mid_reset", start, 0);
    start = det_count;
    run_seq(32'b10010, 5);
    check_hits("after_mid_reset", start, 1);

    // Random stream
    do_reset(2);
    for (int i = 0; i < 255; i++) begin
      step(1'($urandom % 2));
    end
    @(negedge clk);
    #1;

    // Every pushed expectation must have been consumed
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
